// File: rtl/f1_light_seq.sv
// f1_light_seq: tick-driven start-light sequencer feeding the reaction timer.
// Define F1_RANDOM_DELAY_EN to take the hold delay from an internal LFSR instead of DELAY_FIXED.
module f1_light_seq #(
    parameter int unsigned N_LIGHTS    = 8,
    parameter int unsigned LFSR_BITS   = 7,
    parameter int unsigned DELAY_FIXED = 16
) (
    input  logic                clkin,
    input  logic                rst_n,
    input  logic                tick,
    input  logic                trigger,
    output logic [N_LIGHTS-1:0] ledr,
    output logic                cmd_seq,
    output logic                cmd_delay,
    output logic                time_out
);

    typedef enum logic [1:0] {StIdle, StLights, StDelay} state_e;

    state_e               state_q, state_d;
    logic                 trig_q;
    logic                 start;
    logic [N_LIGHTS-1:0]  ledr_q, ledr_d;
    logic [LFSR_BITS-1:0] dcnt_q, dcnt_d;
    logic [LFSR_BITS-1:0] delay_val;
    logic                 time_out_q, time_out_d;

`ifdef F1_RANDOM_DELAY_EN
    logic [LFSR_BITS-1:0] lfsr_q;

    // Fibonacci x^7+x^6+1; free-running so the delay depends on when the user pressed start.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_BITS'(1);
        end else begin
            lfsr_q <= {lfsr_q[LFSR_BITS-2:0], lfsr_q[LFSR_BITS-1] ^ lfsr_q[LFSR_BITS-2]};
        end
    end

    assign delay_val = lfsr_q;
`else
    assign delay_val = LFSR_BITS'(DELAY_FIXED);
`endif

    assign start = trigger & ~trig_q;

    always_comb begin
        state_d    = state_q;
        ledr_d     = ledr_q;
        dcnt_d     = dcnt_q;
        time_out_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLights;
                end
            end
            StLights: begin
                if (tick) begin
                    ledr_d = {ledr_q[N_LIGHTS-2:0], 1'b1};
                    // This tick lights the last LED.
                    if (&ledr_q[N_LIGHTS-2:0]) begin
                        dcnt_d  = delay_val;
                        state_d = StDelay;
                    end
                end
            end
            StDelay: begin
                if (tick) begin
                    dcnt_d = dcnt_q - LFSR_BITS'(1);
                    if (dcnt_q == LFSR_BITS'(1)) begin
                        ledr_d     = '0;
                        time_out_d = 1'b1;
                        state_d    = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            trig_q     <= 1'b0;
            ledr_q     <= '0;
            dcnt_q     <= '0;
            time_out_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            trig_q     <= trigger;
            ledr_q     <= ledr_d;
            dcnt_q     <= dcnt_d;
            time_out_q <= time_out_d;
        end
    end

    assign ledr      = ledr_q;
    assign time_out  = time_out_q;
    assign cmd_seq   = (state_q == StLights);
    assign cmd_delay = (state_q == StDelay);

endmodule

// File: tb/tb_f1_light_seq.sv
// Scoreboard bench for f1_light_seq: stimulus queues expected LED steps and time_out cycles,
// a negedge monitor pops and compares them whenever the outputs change.
module tb_f1_light_seq;
    localparam int N    = 8;
    localparam int DFIX = 16;

    logic         clkin   = 1'b0;
    logic         rst_n   = 1'b0;
    logic         tick    = 1'b0;
    logic         trigger = 1'b0;
    logic [N-1:0] ledr;
    logic         cmd_seq;
    logic         cmd_delay;
    logic         time_out;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [N-1:0] exp_led[$];
    int           exp_to[$];

    f1_light_seq #(
        .N_LIGHTS   (N),
        .LFSR_BITS  (7),
        .DELAY_FIXED(DFIX)
    ) dut (
        .clkin    (clkin),
        .rst_n    (rst_n),
        .tick     (tick),
        .trigger  (trigger),
        .ledr     (ledr),
        .cmd_seq  (cmd_seq),
        .cmd_delay(cmd_delay),
        .time_out (time_out)
    );

    always #5 clkin = ~clkin;
    always @(posedge clkin) cyc <= cyc + 1;

`ifdef F1_RANDOM_DELAY_EN
    logic [6:0] m_lfsr;
    always @(posedge clkin or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 7'd1;
        else        m_lfsr <= {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
    end
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor
    logic [N-1:0] prev_led = '0;
    logic         prev_to  = 1'b0;
    always @(negedge clkin) begin
        if (!rst_n) begin
            prev_led <= '0;
            prev_to  <= 1'b0;
        end else begin
            if (ledr !== prev_led) begin
                if (exp_led.size() == 0) check("ledr_unexpected_change", ledr, prev_led);
                else                     check("ledr_step", ledr, exp_led.pop_front());
                if (&ledr) check("cmd_delay_at_full", cmd_delay, 1);
                if (ledr != 0 && !(&ledr)) check("cmd_seq_lights", cmd_seq, 1);
            end
            if (time_out) begin
                if (exp_to.size() == 0) check("time_out_unexpected", time_out, 0);
                else                    check("time_out_cycle", cyc, exp_to.pop_front());
                check("ledr_at_time_out", ledr, 0);
                check("cmd_delay_at_time_out", cmd_delay, 0);
            end
            if (prev_to) check("time_out_width", time_out, 0);
            prev_led <= ledr;
            prev_to  <= time_out;
        end
    end

    // One start edge, then ticks every `period` cycles until the sequence should end.
    task automatic run_seq(input int period, input bit coinc, input bit hold, input bit glitch,
                           input bit abort);
        int nt;
        int i;
        int target;
        bit aborted;
        target  = N + DFIX;
        aborted = 1'b0;
        for (int k = 1; k <= N; k++) exp_led.push_back(N'((1 << k) - 1));
        if (!abort) exp_led.push_back('0);
        trigger = 1'b1;
        tick    = coinc;
        @(posedge clkin); #1;
        check("cmd_seq_after_start", cmd_seq, 1);
        check("ledr_after_start", ledr, 0);
        if (!hold) trigger = 1'b0;
        nt = 0;
        i  = 0;
        while (nt < target) begin
            i++;
            tick = (i % period == 0);
            if (glitch) trigger = i[1];
            if (tick) begin
                nt++;
`ifdef F1_RANDOM_DELAY_EN
                if (nt == N) begin
                    check("delay_nonzero", {31'd0, m_lfsr != 7'd0}, 1);
                    target = N + int'(m_lfsr);
                end
`endif
                if (nt == target) exp_to.push_back(cyc + 1);
            end
            @(posedge clkin); #1;
            if (abort && nt == N + 1 && nt < target) begin
                #1 rst_n = 1'b0;
                #1;
                check("rst_async_ledr", ledr, 0);
                check("rst_async_cmd_delay", cmd_delay, 0);
                check("rst_async_time_out", time_out, 0);
                exp_led.delete();
                exp_to.delete();
                tick    = 1'b0;
                trigger = 1'b0;
                @(posedge clkin); #2;
                rst_n = 1'b1;
`ifdef F1_RANDOM_DELAY_EN
                check("lfsr_after_reset", dut.lfsr_q, 1);
`endif
                aborted = 1'b1;
                break;
            end
        end
        trigger = hold;
        // Keep ticking: nothing may restart or pulse again.
        repeat (12) begin
            tick = 1'b1;
            @(posedge clkin); #1;
        end
        if (!aborted) check("idle_after_seq", {31'd0, cmd_seq | cmd_delay}, 0);
        tick    = 1'b0;
        trigger = 1'b0;
        repeat (2) begin
            @(posedge clkin); #1;
        end
    endtask

    initial begin
        #3;
        check("reset_ledr", ledr, 0);
        check("reset_time_out", time_out, 0);
        check("reset_cmd_seq", cmd_seq, 0);
        check("reset_cmd_delay", cmd_delay, 0);
        repeat (2) @(posedge clkin);
        #1 rst_n = 1'b1;
`ifdef F1_RANDOM_DELAY_EN
        check("lfsr_reset_value", dut.lfsr_q, 1);
`endif
        repeat (3) begin
            @(posedge clkin); #1;
        end
        run_seq(4, 1'b0, 1'b0, 1'b0, 1'b0);  // basic
        run_seq(4, 1'b1, 1'b0, 1'b0, 1'b0);  // tick coincident with start
        run_seq(4, 1'b0, 1'b1, 1'b0, 1'b0);  // trigger held high
        run_seq(3, 1'b0, 1'b0, 1'b1, 1'b0);  // extra start edges ignored
        run_seq(1, 1'b0, 1'b0, 1'b0, 1'b0);  // back-to-back ticks
        run_seq(2, 1'b0, 1'b0, 1'b0, 1'b1);  // async reset mid-DELAY
        run_seq(1, 1'b0, 1'b0, 1'b0, 1'b0);  // recovers after reset
`ifdef F1_RANDOM_DELAY_EN
        for (int r = 0; r < 50; r++) begin
            repeat (r % 5) begin
                @(posedge clkin); #1;
            end
            run_seq(1 + (r % 2), 1'b0, 1'b0, 1'b0, 1'b0);
        end
`endif
        repeat (3) begin
            @(posedge clkin); #1;
        end
        check("exp_led_drained", exp_led.size(), 0);
        check("exp_to_drained", exp_to.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
